nios2_tas_i2c_master: RTL and testbench

Hardware I2C write master for the TAS audio codec control bus. It replaces software bit-banging of the codec's SDA/SCL PIO pins. It is an Avalon-MM slave on the Nios II data bus. Software writes one 32-bit word containing device address, register address and data. The block then sequences START, three bytes with ACK checks, and STOP on open-drain SCL/SDA, and reports busy/NACK/done status with an optional level interrupt.

---
 rtl/nios2_tas_i2c_pkg.sv | 30 +++
 rtl/nios2_tas_i2c_tick.sv | 28 ++
 rtl/nios2_tas_i2c_master.sv | 204 ++++++++++++++++++++
 tb/tb_nios2_tas_i2c_master.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_tas_i2c_pkg.sv
// Shared types and constants for the TAS codec I2C write master.
package nios2_tas_i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP
    } state_t;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_NACK = 1;
    localparam int STAT_OVR  = 2;
    localparam int STAT_DONE = 3;

    // Number of quarter periods spent in each phase of the transfer
    localparam logic [2:0] START_QUARTERS = 3'd2;
    localparam logic [2:0] BIT_QUARTERS   = 3'd4;
    localparam logic [2:0] STOP_QUARTERS  = 3'd3;

    localparam logic [2:0] LAST_BIT  = 3'd7;
    localparam logic [1:0] LAST_BYTE = 2'd2;

endpackage

// File: rtl/nios2_tas_i2c_tick.sv
// Quarter-SCL-period down-counter; emits a one-cycle qtick at the end of each quarter.
module nios2_tas_i2c_tick (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] div,
    input  logic        enable,
    input  logic        stretch_hold,
    output logic        qtick
);

    logic [15:0] cnt;
    logic [15:0] reload;

    // A divider of 0 gives the same one-cycle quarter as a divider of 1
    assign reload = (div == 16'd0) ? 16'd0 : div - 16'd1;
    assign qtick  = enable && !stretch_hold && (cnt == 16'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 16'd0;
        end else if (!enable || qtick) begin
            cnt <= reload;
        end else if (!stretch_hold) begin
            cnt <= cnt - 16'd1;
        end
    end

endmodule

// File: rtl/nios2_tas_i2c_master.sv
// Avalon-MM I2C write master: one TXDATA write sends START, dev/reg/data bytes with ACK checks, STOP.
module nios2_tas_i2c_master
    import nios2_tas_i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        scl_oe,
    output logic        sda_oe
);

    state_t      state, state_d;
    logic [1:0]  q, q_d;
    logic [2:0]  bit_cnt, bit_cnt_d;
    logic [1:0]  byte_cnt, byte_cnt_d;
    logic [7:0]  shreg, shreg_d;
    logic [15:0] tx_q;
    logic [15:0] div_q;
    logic        nack, ovr, done;
    logic        busy, qtick, stretch_hold;
    logic        wr, tx_start, ovr_set, nack_set, done_set;
    logic [3:0]  stat_clr;
    logic        unused_wdata;

    assign busy         = (state != ST_IDLE);
    assign wr           = chipselect && !write_n;
    assign tx_start     = wr && (address == REG_TXDATA) && !busy;
    assign ovr_set      = wr && (address == REG_TXDATA) && busy;
    assign stat_clr     = (wr && (address == REG_STATUS)) ? writedata[3:0] : 4'd0;
    assign nack_set     = (state == ST_ACK) && ({1'b0, q} == BIT_QUARTERS - 3'd1) && qtick && sda_in;
    assign done_set     = (state == ST_STOP) && ({1'b0, q} == STOP_QUARTERS - 3'd1) && qtick;
    // Only a released SCL held low by the slave can stretch a quarter
    assign stretch_hold = busy && !scl_oe && !scl_in;
    assign irq          = done;
    assign unused_wdata = ^writedata[31:23];

    nios2_tas_i2c_tick u_tick (
        .clk          (clk),
        .reset_n      (reset_n),
        .div          (div_q),
        .enable       (busy),
        .stretch_hold (stretch_hold),
        .qtick        (qtick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            q        <= 2'd0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 2'd0;
            shreg    <= 8'd0;
        end else begin
            state    <= state_d;
            q        <= q_d;
            bit_cnt  <= bit_cnt_d;
            byte_cnt <= byte_cnt_d;
            shreg    <= shreg_d;
        end
    end

    always_comb begin
        state_d    = state;
        q_d        = q;
        bit_cnt_d  = bit_cnt;
        byte_cnt_d = byte_cnt;
        shreg_d    = shreg;
        case (state)
            ST_IDLE: begin
                if (tx_start) begin
                    state_d    = ST_START;
                    q_d        = 2'd0;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 2'd0;
                    shreg_d    = {writedata[22:16], 1'b0};
                end
            end
            ST_START: begin
                if (qtick) begin
                    if ({1'b0, q} == START_QUARTERS - 3'd1) begin
                        state_d = ST_BIT;
                        q_d     = 2'd0;
                    end else begin
                        q_d = q + 2'd1;
                    end
                end
            end
            ST_BIT: begin
                if (qtick) begin
                    if ({1'b0, q} == BIT_QUARTERS - 3'd1) begin
                        q_d = 2'd0;
                        if (bit_cnt == LAST_BIT) begin
                            state_d = ST_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt + 3'd1;
                            shreg_d   = {shreg[6:0], 1'b0};
                        end
                    end else begin
                        q_d = q + 2'd1;
                    end
                end
            end
            ST_ACK: begin
                if (qtick) begin
                    if ({1'b0, q} == BIT_QUARTERS - 3'd1) begin
                        q_d = 2'd0;
                        // A NACK abandons the remaining bytes
                        if (sda_in || (byte_cnt == LAST_BYTE)) begin
                            state_d = ST_STOP;
                        end else begin
                            state_d    = ST_BIT;
                            bit_cnt_d  = 3'd0;
                            byte_cnt_d = byte_cnt + 2'd1;
                            shreg_d    = (byte_cnt == 2'd0) ? tx_q[15:8] : tx_q[7:0];
                        end
                    end else begin
                        q_d = q + 2'd1;
                    end
                end
            end
            ST_STOP: begin
                if (qtick) begin
                    if ({1'b0, q} == STOP_QUARTERS - 3'd1) begin
                        state_d = ST_IDLE;
                        q_d     = 2'd0;
                    end else begin
                        q_d = q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state)
            ST_START: sda_oe = (q == 2'd1);
            ST_BIT: begin
                scl_oe = ~q[1];
                sda_oe = ~shreg[7];
            end
            ST_ACK:   scl_oe = ~q[1];
            ST_STOP: begin
                scl_oe = (q == 2'd0);
                sda_oe = (q != 2'd2);
            end
            default: begin
                scl_oe = 1'b0;
                sda_oe = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_q  <= 16'd0;
            div_q <= 16'(CLK_DIV);
        end else begin
            if (tx_start) begin
                tx_q <= writedata[15:0];
            end
            if (wr && (address == REG_DIV) && !busy) begin
                div_q <= writedata[15:0];
            end
        end
    end

    // Hardware sets take priority over software write-1-to-clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nack <= 1'b0;
            ovr  <= 1'b0;
            done <= 1'b0;
        end else begin
            nack <= (nack & ~stat_clr[STAT_NACK]) | nack_set;
            ovr  <= (ovr  & ~stat_clr[STAT_OVR])  | ovr_set;
            done <= (done & ~stat_clr[STAT_DONE]) | done_set;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'd0;
        end else begin
            case (address)
                REG_STATUS: readdata <= {28'd0, done, ovr, nack, busy};
                REG_DIV:    readdata <= {16'd0, div_q};
                default:    readdata <= 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_tas_i2c_master.sv
// Directed bench for nios2_tas_i2c_master with an open-drain bus model and an ACKing slave.
module tb_nios2_tas_i2c_master;
    import nios2_tas_i2c_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        scl_in, sda_in, scl_oe, sda_oe;

    logic        stretch_low;
    logic        slave_low;
    logic        mon_clear;
    int          nack_byte;

    logic [31:0] rx_word;
    int          rx_n;
    int          mon_nbits;
    int          mon_byte;
    int          busy_cycles;
    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;

    int vec_count = 0;
    int err_count = 0;

    always #5 clk = ~clk;

    // Open-drain wires with pull-ups
    assign scl_in = !(scl_oe || stretch_low);
    assign sda_in = !(sda_oe || slave_low);

    nios2_tas_i2c_master #(.CLK_DIV(125)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .scl_oe     (scl_oe),
        .sda_oe     (sda_oe)
    );

    // Bus monitor and slave: samples SDA on each SCL rise, ACKs every byte except nack_byte
    always @(negedge clk) begin
        if (!reset_n || mon_clear) begin
            rx_word     = 32'd0;
            rx_n        = 0;
            mon_nbits   = 0;
            mon_byte    = 0;
            slave_low   = 1'b0;
            busy_cycles = 0;
        end else begin
            if (readdata[STAT_BUSY]) busy_cycles++;
            if (prev_sda && !sda_in && prev_scl && scl_in) begin
                mon_nbits = 0;
                mon_byte  = 0;
            end
            if (!prev_scl && scl_in) begin
                rx_word = {rx_word[30:0], sda_in};
                rx_n++;
                mon_nbits++;
            end
            if (prev_scl && !scl_in) begin
                if (mon_nbits == 8) begin
                    slave_low = (mon_byte != nack_byte);
                end else if (mon_nbits == 9) begin
                    slave_low = 1'b0;
                    mon_nbits = 0;
                    mon_byte++;
                end
            end
        end
        prev_scl = scl_in;
        prev_sda = sda_in;
    end

    // Expected SDA samples at SCL rises: bytes MSB first, ACK slot, then the STOP release (SDA low)
    function automatic void exp_bits(input logic [23:0] tx, input int nk,
                                     output logic [31:0] w, output int n);
        logic [7:0] b [3];
        b[0] = {tx[22:16], 1'b0};
        b[1] = tx[15:8];
        b[2] = tx[7:0];
        w = 32'd0;
        n = 0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 7; i >= 0; i--) begin
                w = {w[30:0], b[k][i]};
                n++;
            end
            w = {w[30:0], (k == nk) ? 1'b1 : 1'b0};
            n++;
            if (k == nk) break;
        end
        w = {w[30:0], 1'b0};
        n++;
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        write_n    = 1'b1;
        address    = REG_STATUS;
        writedata  = 32'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        write_n = 1'b1;
        address = a;
        @(negedge clk);
        d       = readdata;
        address = REG_STATUS;
    endtask

    task automatic start_xfer(input logic [31:0] d);
        mon_clear = 1'b1;
        @(negedge clk);
        #1 mon_clear = 1'b0;
        bus_write(REG_TXDATA, d);
    endtask

    // Polls STATUS until done shows; returns the busy bit and irq levels of the preceding samples
    task automatic wait_done(input int budget, output logic found,
                             output logic busy_before, output logic [1:0] irq_hist);
        logic       prev_busy;
        logic [1:0] ih;
        found = 1'b0; prev_busy = 1'b0; ih = 2'b00; busy_before = 1'b0; irq_hist = 2'b00;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (readdata[STAT_DONE]) begin
                found = 1'b1; busy_before = prev_busy; irq_hist = ih;
                break;
            end
            prev_busy = readdata[STAT_BUSY];
            ih = {ih[0], irq};
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        vec_count++; if (scl_oe !== 1'b0 || sda_oe !== 1'b0) begin err_count++; $display("FAIL reset_pins: scl_oe=%b sda_oe=%b expected 0 0", scl_oe, sda_oe); end
        vec_count++; if (irq !== 1'b0) begin err_count++; $display("FAIL reset_irq: got %b expected 0", irq); end
        bus_read(REG_STATUS, rd);
        vec_count++; if (rd !== 32'd0) begin err_count++; $display("FAIL reset_status: got %h expected 0", rd); end
        bus_read(REG_DIV, rd);
        vec_count++; if (rd !== 32'd125) begin err_count++; $display("FAIL reset_div: got %0d expected 125", rd); end
        bus_write(REG_RSVD, 32'hFFFF_FFFF);
        bus_read(REG_RSVD, rd);
        vec_count++; if (rd !== 32'd0) begin err_count++; $display("FAIL reserved_read: got %h expected 0", rd); end
        bus_read(REG_TXDATA, rd);
        vec_count++; if (rd !== 32'd0) begin err_count++; $display("FAIL txdata_read: got %h expected 0", rd); end
        bus_write(REG_DIV, 32'd4);
        bus_read(REG_DIV, rd);
        vec_count++; if (rd !== 32'd4) begin err_count++; $display("FAIL div_write: got %0d expected 4", rd); end
    endtask

    task automatic test_ack_all();
        logic [31:0] rd, ew;
        logic        found, bb;
        logic [1:0]  ih;
        int          en;
        nack_byte = 3;
        start_xfer(32'h001B_2A5C);
        wait_done(5000, found, bb, ih);
        exp_bits(24'h1B2A5C, 3, ew, en);
        vec_count++; if (!found) begin err_count++; $display("FAIL ack_all_timeout: done not seen within 5000 cycles"); end
        vec_count++; if (busy_cycles !== 452) begin err_count++; $display("FAIL ack_all_busy: got %0d cycles expected 452", busy_cycles); end
        vec_count++; if (bb !== 1'b1 || ih !== 2'b01) begin err_count++; $display("FAIL ack_all_edge: busy_before=%b irq_hist=%b expected 1 01", bb, ih); end
        vec_count++; if (rx_n !== en || rx_word !== ew) begin err_count++; $display("FAIL ack_all_bits: got %0d/%h expected %0d/%h", rx_n, rx_word, en, ew); end
        bus_read(REG_STATUS, rd);
        vec_count++; if (rd !== 32'h8 || irq !== 1'b1) begin err_count++; $display("FAIL ack_all_status: got %h irq=%b expected 8 1", rd, irq); end
        bus_write(REG_STATUS, 32'hE);
        bus_read(REG_STATUS, rd);
        vec_count++; if (rd !== 32'd0 || irq !== 1'b0) begin err_count++; $display("FAIL ack_all_clear: got %h irq=%b expected 0 0", rd, irq); end
    endtask

    task automatic test_nack();
        logic [31:0] rd, ew;
        logic        found, bb;
        logic [1:0]  ih;
        int          en;
        nack_byte = 1;
        start_xfer(32'h001B_2A5C);
        wait_done(5000, found, bb, ih);
        exp_bits(24'h1B2A5C, 1, ew, en);
        vec_count++; if (!found) begin err_count++; $display("FAIL nack_timeout: done not seen within 5000 cycles"); end
        vec_count++; if (busy_cycles !== 308) begin err_count++; $display("FAIL nack_busy: got %0d cycles expected 308", busy_cycles); end
        vec_count++; if (rx_n !== en || rx_word !== ew) begin err_count++; $display("FAIL nack_bits: got %0d/%h expected %0d/%h", rx_n, rx_word, en, ew); end
        bus_read(REG_STATUS, rd);
        vec_count++; if (rd !== 32'hA) begin err_count++; $display("FAIL nack_status: got %h expected a", rd); end
        bus_write(REG_STATUS, 32'hE);
        nack_byte = 3;
    endtask

    task automatic test_overrun();
        logic [31:0] rd, ew;
        logic        found, bb;
        logic [1:0]  ih;
        int          en;
        nack_byte = 3;
        start_xfer(32'h001B_2A5C);
        repeat (40) @(negedge clk);
        bus_write(REG_TXDATA, 32'h0011_2233);
        wait_done(5000, found, bb, ih);
        exp_bits(24'h1B2A5C, 3, ew, en);
        vec_count++; if (!found) begin err_count++; $display("FAIL ovr_timeout: done not seen within 5000 cycles"); end
        vec_count++; if (rx_n !== en || rx_word !== ew) begin err_count++; $display("FAIL ovr_bits: got %0d/%h expected %0d/%h", rx_n, rx_word, en, ew); end
        bus_read(REG_STATUS, rd);
        vec_count++; if (rd !== 32'hC || irq !== 1'b1) begin err_count++; $display("FAIL ovr_status: got %h irq=%b expected c 1", rd, irq); end
        bus_write(REG_STATUS, 32'hE);
        bus_read(REG_STATUS, rd);
        vec_count++; if (rd !== 32'd0 || irq !== 1'b0) begin err_count++; $display("FAIL ovr_clear: got %h irq=%b expected 0 0", rd, irq); end
        repeat (20) @(negedge clk);
        vec_count++; if (scl_oe !== 1'b0 || sda_oe !== 1'b0) begin err_count++; $display("FAIL ovr_no_restart: scl_oe=%b sda_oe=%b expected 0 0", scl_oe, sda_oe); end
    endtask

    task automatic test_stretch();
        logic [31:0] rd, ew;
        logic        found, bb, armed, released;
        logic [1:0]  ih;
        int          en;
        nack_byte = 3;
        armed = 1'b0; released = 1'b0;
        start_xfer(32'h001B_2A5C);
        fork
            begin
                for (int i = 0; i < 3000; i++) begin
                    @(negedge clk);
                    if (mon_byte == 1 && mon_nbits == 3 && scl_oe) begin armed = 1'b1; break; end
                end
                if (armed) begin
                    stretch_low = 1'b1;
                    for (int i = 0; i < 100; i++) begin
                        @(negedge clk);
                        if (!scl_oe) begin released = 1'b1; break; end
                    end
                    repeat (20) @(negedge clk);
                    stretch_low = 1'b0;
                end
            end
            wait_done(5000, found, bb, ih);
        join
        exp_bits(24'h1B2A5C, 3, ew, en);
        vec_count++; if (!armed || !released) begin err_count++; $display("FAIL stretch_window: armed=%b released=%b expected 1 1", armed, released); end
        vec_count++; if (!found) begin err_count++; $display("FAIL stretch_timeout: done not seen within 5000 cycles"); end
        vec_count++; if (busy_cycles !== 472) begin err_count++; $display("FAIL stretch_busy: got %0d cycles expected 472", busy_cycles); end
        vec_count++; if (rx_n !== en || rx_word !== ew) begin err_count++; $display("FAIL stretch_bits: got %0d/%h expected %0d/%h", rx_n, rx_word, en, ew); end
        bus_read(REG_STATUS, rd);
        vec_count++; if (rd !== 32'h8) begin err_count++; $display("FAIL stretch_status: got %h expected 8", rd); end
        bus_write(REG_STATUS, 32'hE);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, ew;
        logic        found, bb, hit;
        logic [1:0]  ih;
        int          en;
        nack_byte = 3;
        hit = 1'b0;
        start_xfer(32'h001B_2A5C);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (mon_byte == 2 && scl_oe) begin hit = 1'b1; break; end
        end
        vec_count++; if (!hit) begin err_count++; $display("FAIL rst_mid_window: byte 2 not reached within 3000 cycles"); end
        reset_n = 1'b0;
        #1;
        vec_count++; if (scl_oe !== 1'b0 || sda_oe !== 1'b0) begin err_count++; $display("FAIL rst_mid_pins: scl_oe=%b sda_oe=%b expected 0 0", scl_oe, sda_oe); end
        vec_count++; if (readdata !== 32'd0 || irq !== 1'b0) begin err_count++; $display("FAIL rst_mid_regs: readdata=%h irq=%b expected 0 0", readdata, irq); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus_read(REG_STATUS, rd);
        vec_count++; if (rd !== 32'd0) begin err_count++; $display("FAIL rst_mid_status: got %h expected 0", rd); end
        bus_write(REG_DIV, 32'd4);
        start_xfer(32'h001B_2A5C);
        wait_done(5000, found, bb, ih);
        exp_bits(24'h1B2A5C, 3, ew, en);
        vec_count++; if (!found || busy_cycles !== 452) begin err_count++; $display("FAIL rst_mid_rerun: found=%b busy=%0d expected 1 452", found, busy_cycles); end
        vec_count++; if (rx_n !== en || rx_word !== ew) begin err_count++; $display("FAIL rst_mid_bits: got %0d/%h expected %0d/%h", rx_n, rx_word, en, ew); end
        bus_write(REG_STATUS, 32'hE);
    endtask

    task automatic test_div();
        logic [31:0] rd, ew;
        logic        found, bb;
        logic [1:0]  ih;
        int          en;
        nack_byte = 3;
        start_xfer(32'h0050_0F81);
        repeat (30) @(negedge clk);
        bus_write(REG_DIV, 32'd9);
        wait_done(5000, found, bb, ih);
        exp_bits(24'h500F81, 3, ew, en);
        vec_count++; if (!found || rx_n !== en || rx_word !== ew) begin err_count++; $display("FAIL div_busy_xfer: found=%b got %0d/%h expected %0d/%h", found, rx_n, rx_word, en, ew); end
        bus_read(REG_DIV, rd);
        vec_count++; if (rd !== 32'd4) begin err_count++; $display("FAIL div_busy_ignored: got %0d expected 4", rd); end
        bus_write(REG_STATUS, 32'hE);
        bus_write(REG_DIV, 32'd0);
        bus_read(REG_DIV, rd);
        vec_count++; if (rd !== 32'd0) begin err_count++; $display("FAIL div_zero_read: got %0d expected 0", rd); end
        start_xfer(32'h001B_2A5C);
        wait_done(1000, found, bb, ih);
        exp_bits(24'h1B2A5C, 3, ew, en);
        vec_count++; if (!found || busy_cycles !== 113) begin err_count++; $display("FAIL div_zero_busy: found=%b busy=%0d expected 1 113", found, busy_cycles); end
        vec_count++; if (rx_n !== en || rx_word !== ew) begin err_count++; $display("FAIL div_zero_bits: got %0d/%h expected %0d/%h", rx_n, rx_word, en, ew); end
        vec_count++; if (bb !== 1'b1 || ih !== 2'b01) begin err_count++; $display("FAIL div_zero_edge: busy_before=%b irq_hist=%b expected 1 01", bb, ih); end
    endtask

    initial begin
        reset_n     = 1'b0;
        chipselect  = 1'b1;
        write_n     = 1'b1;
        address     = REG_STATUS;
        writedata   = 32'd0;
        stretch_low = 1'b0;
        mon_clear   = 1'b0;
        nack_byte   = 3;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_ack_all();
        test_nack();
        test_overrun();
        test_stretch();
        test_reset_mid();
        test_div();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
